// File: rtl/edge_gen_pkg.sv
// edge_gen_pkg: shared state encoding and default widths for the edge_gen pulse-train generator.
package edge_gen_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int LEN_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/edge_gen_if.sv
// edge_gen_if: request/waveform bundle between a burst requester (master) and edge_gen (slave).
// The abort wire exists only when EDGE_GEN_ABORT_EN is defined.
interface edge_gen_if #(
    parameter int CNT_W = 8,
    parameter int LEN_W = 8
);
`ifdef EDGE_GEN_ABORT_EN
    logic             abort;
`endif
    logic             start;
    logic [CNT_W-1:0] num_pulses;
    logic [LEN_W-1:0] high_len;
    logic [LEN_W-1:0] low_len;
    logic             pulse_o;
    logic             rise_o;
    logic             fall_o;
    logic             busy;
    logic             done;

    modport master (
`ifdef EDGE_GEN_ABORT_EN
        output abort,
`endif
        output start, num_pulses, high_len, low_len,
        input  pulse_o, rise_o, fall_o, busy, done
    );

    modport slave (
`ifdef EDGE_GEN_ABORT_EN
        input  abort,
`endif
        input  start, num_pulses, high_len, low_len,
        output pulse_o, rise_o, fall_o, busy, done
    );
endinterface

// File: rtl/edge_gen_cnt.sv
// edge_gen_cnt: loadable down-counter with enable and zero flag; used as the phase-length counter.
// Holds at zero rather than wrapping, so an idle enable cannot corrupt the next load.
module edge_gen_cnt #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             en,
    input  logic [LEN_W-1:0] load_val,
    output logic             zero
);
    logic [LEN_W-1:0] cnt_q, cnt_d;

    // Load has priority over counting; count down only while non-zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && (cnt_q != '0))
            cnt_d = cnt_q - LEN_W'(1);
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/edge_gen.sv
// edge_gen: programmable burst of N pulses (H cycles high, L cycles low) with registered
// rise/fall strobes, busy and a done strobe. Define EDGE_GEN_ABORT_EN to add an abort input
// that ends a burst early from HIGH or LOW.
module edge_gen
    import edge_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    edge_gen_if.slave  bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;       // pulses still to emit, including the current one
    logic [LEN_W-1:0] h_q, h_d;           // latched H-1 (zero H treated as 1)
    logic [LEN_W-1:0] l_q, l_d;           // latched L-1 (zero L treated as 1)
    logic             pulse_q, pulse_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ph_load, ph_en, ph_zero;
    logic [LEN_W-1:0] ph_val;
    logic             abort_w;

`ifdef EDGE_GEN_ABORT_EN
    assign abort_w = bus.abort;
`else
    assign abort_w = 1'b0;
`endif

    edge_gen_cnt #(.LEN_W(LEN_W)) u_phase (
        .clk      (clk),
        .rstn     (rstn),
        .load     (ph_load),
        .en       (ph_en),
        .load_val (ph_val),
        .zero     (ph_zero)
    );

    // Next state, counter control and next registered outputs; strobes default low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_d     = h_q;
        l_d     = l_q;
        pulse_d = 1'b0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        ph_load = 1'b0;
        ph_en   = 1'b0;
        ph_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    h_d   = (bus.high_len == '0) ? '0 : LEN_W'(bus.high_len - LEN_W'(1));
                    l_d   = (bus.low_len  == '0) ? '0 : LEN_W'(bus.low_len  - LEN_W'(1));
                    cnt_d = CNT_W'(bus.num_pulses);
                    if (bus.num_pulses == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_HIGH;
                        pulse_d = 1'b1;
                        rise_d  = 1'b1;
                        busy_d  = 1'b1;
                        ph_load = 1'b1;
                        ph_val  = h_d;
                    end
                end
            end
            ST_HIGH: begin
                if (abort_w) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    fall_d  = 1'b1;
                end else if (ph_zero) begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    fall_d = 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOW;
                        busy_d  = 1'b1;
                        ph_load = 1'b1;
                        ph_val  = l_q;
                    end
                end else begin
                    pulse_d = 1'b1;
                    busy_d  = 1'b1;
                    ph_en   = 1'b1;
                end
            end
            ST_LOW: begin
                if (abort_w) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (ph_zero) begin
                    state_d = ST_HIGH;
                    pulse_d = 1'b1;
                    rise_d  = 1'b1;
                    busy_d  = 1'b1;
                    ph_load = 1'b1;
                    ph_val  = h_q;
                end else begin
                    busy_d = 1'b1;
                    ph_en  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched burst parameters and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            h_q     <= '0;
            l_q     <= '0;
            pulse_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            l_q     <= l_d;
            pulse_q <= pulse_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.pulse_o = pulse_q;
    assign bus.rise_o  = rise_q;
    assign bus.fall_o  = fall_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_edge_gen.sv
// tb_edge_gen: directed tests for edge_gen; waveforms are captured one bit per cycle
// (bit c = cycle c after the start edge) and compared with hand-computed vectors.
module tb_edge_gen;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    edge_gen_if #(.CNT_W(8), .LEN_W(8)) bus ();

    edge_gen #(.CNT_W(8), .LEN_W(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Drive one burst and record outputs for ncyc cycles; smask/amask bit c drives
    // start/abort sampled at edge c; high_len switches to h_mid after the start edge.
    task automatic run(input logic [7:0] n, input logic [7:0] h, input logic [7:0] l,
                       input logic [7:0] h_mid, input logic [31:0] smask,
                       input logic [31:0] amask, input int ncyc,
                       output logic [31:0] pw, output logic [31:0] rw, output logic [31:0] fw,
                       output logic [31:0] bw, output logic [31:0] dw);
        pw = '0; rw = '0; fw = '0; bw = '0; dw = '0;
        @(negedge clk);
        bus.num_pulses = n;
        bus.high_len   = h;
        bus.low_len    = l;
        bus.start      = smask[0];
`ifdef EDGE_GEN_ABORT_EN
        bus.abort      = amask[0];
`endif
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            pw[c] = bus.pulse_o;
            rw[c] = bus.rise_o;
            fw[c] = bus.fall_o;
            bw[c] = bus.busy;
            dw[c] = bus.done;
            bus.start = smask[c];
`ifdef EDGE_GEN_ABORT_EN
            bus.abort = amask[c];
`endif
            if (c == 1) bus.high_len = h_mid;
        end
        bus.start = 1'b0;
`ifdef EDGE_GEN_ABORT_EN
        bus.abort = 1'b0;
`endif
    endtask

    task automatic test_reset();
        logic [4:0] got;
        bus.start = 1'b0; bus.num_pulses = '0; bus.high_len = '0; bus.low_len = '0;
`ifdef EDGE_GEN_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        got = {bus.pulse_o, bus.rise_o, bus.fall_o, bus.busy, bus.done};
        n_total++;
        if (got !== 5'b0) $display("FAIL reset_outputs got %b exp 00000", got);
        else n_pass++;
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        got = {bus.pulse_o, bus.rise_o, bus.fall_o, bus.busy, bus.done};
        n_total++;
        if (got !== 5'b0) $display("FAIL idle_outputs got %b exp 00000", got);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [31:0] got[5], exp[5];
        string nm[5] = '{"pulse", "rise", "fall", "busy", "done"};
        run(8'd3, 8'd2, 8'd1, 8'd2, 32'h1, 32'h0, 12, got[0], got[1], got[2], got[3], got[4]);
        exp = '{32'h1B6, 32'h92, 32'h248, 32'h1FE, 32'h200};
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (got[i] !== exp[i]) $display("FAIL basic_%s got %h exp %h", nm[i], got[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_degenerate();
        logic [31:0] got[5], exp[5];
        string nm[5] = '{"pulse", "rise", "fall", "busy", "done"};
        run(8'd0, 8'd5, 8'd5, 8'd5, 32'h1, 32'h0, 4, got[0], got[1], got[2], got[3], got[4]);
        exp = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h2};
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (got[i] !== exp[i]) $display("FAIL n0_%s got %h exp %h", nm[i], got[i], exp[i]);
            else n_pass++;
        end
        run(8'd1, 8'd0, 8'd0, 8'd0, 32'h1, 32'h0, 5, got[0], got[1], got[2], got[3], got[4]);
        exp = '{32'h2, 32'h2, 32'h4, 32'h2, 32'h4};
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (got[i] !== exp[i]) $display("FAIL n1h0_%s got %h exp %h", nm[i], got[i], exp[i]);
            else n_pass++;
        end
    endtask

    // start held through the whole burst and its done cycle is ignored; the start
    // sampled in the IDLE cycle after done launches an identical second burst.
    task automatic test_back_to_back();
        logic [31:0] got[5], exp[5];
        string nm[5] = '{"pulse", "rise", "fall", "busy", "done"};
        run(8'd2, 8'd3, 8'd2, 8'd3, 32'h7FF, 32'h0, 20, got[0], got[1], got[2], got[3], got[4]);
        exp = '{32'h739CE, 32'h10842, 32'h84210, 32'h7F9FE, 32'h80200};
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (got[i] !== exp[i]) $display("FAIL b2b_%s got %h exp %h", nm[i], got[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_input_change();
        logic [31:0] got[5], exp[5];
        string nm[5] = '{"pulse", "rise", "fall", "busy", "done"};
        run(8'd2, 8'd4, 8'd1, 8'd1, 32'h1, 32'h0, 12, got[0], got[1], got[2], got[3], got[4]);
        exp = '{32'h3DE, 32'h42, 32'h420, 32'h3FE, 32'h400};
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (got[i] !== exp[i]) $display("FAIL midchg_%s got %h exp %h", nm[i], got[i], exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0]  got;
        logic        done_seen;
        logic [31:0] gv[5], exp[5];
        string nm[5] = '{"pulse", "rise", "fall", "busy", "done"};
        @(negedge clk);
        bus.num_pulses = 8'd4; bus.high_len = 8'd2; bus.low_len = 8'd2; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        // cycle 5: first cycle of the second HIGH phase
        got = {bus.pulse_o, bus.rise_o, bus.fall_o, bus.busy, bus.done};
        n_total++;
        if (got !== 5'b11010) $display("FAIL rstmid_pre got %b exp 11010", got);
        else n_pass++;
        #1 rstn = 1'b0;
        #1 got = {bus.pulse_o, bus.rise_o, bus.fall_o, bus.busy, bus.done};
        n_total++;
        if (got !== 5'b0) $display("FAIL rstmid_async got %b exp 00000", got);
        else n_pass++;
        done_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            done_seen = done_seen | bus.done | bus.busy | bus.pulse_o;
        end
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            done_seen = done_seen | bus.done | bus.busy | bus.pulse_o;
        end
        n_total++;
        if (done_seen !== 1'b0) $display("FAIL rstmid_quiet got %b exp 0", done_seen);
        else n_pass++;
        run(8'd3, 8'd2, 8'd1, 8'd2, 32'h1, 32'h0, 12, gv[0], gv[1], gv[2], gv[3], gv[4]);
        exp = '{32'h1B6, 32'h92, 32'h248, 32'h1FE, 32'h200};
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (gv[i] !== exp[i]) $display("FAIL rstmid_after_%s got %h exp %h", nm[i], gv[i], exp[i]);
            else n_pass++;
        end
    endtask

`ifdef EDGE_GEN_ABORT_EN
    task automatic test_abort();
        logic [31:0] got[5], exp[5];
        string nm[5] = '{"pulse", "rise", "fall", "busy", "done"};
        // abort sampled at edge 4, inside the first LOW gap
        run(8'd5, 8'd2, 8'd3, 8'd2, 32'h1, 32'h10, 8, got[0], got[1], got[2], got[3], got[4]);
        exp = '{32'h6, 32'h2, 32'h8, 32'h1E, 32'h20};
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (got[i] !== exp[i]) $display("FAIL abort_low_%s got %h exp %h", nm[i], got[i], exp[i]);
            else n_pass++;
        end
        // abort at edge 0 (IDLE, ignored) and at edge 6, inside the second HIGH phase
        run(8'd5, 8'd2, 8'd3, 8'd2, 32'h1, 32'h41, 8, got[0], got[1], got[2], got[3], got[4]);
        exp = '{32'h46, 32'h42, 32'h88, 32'h7E, 32'h80};
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (got[i] !== exp[i]) $display("FAIL abort_high_%s got %h exp %h", nm[i], got[i], exp[i]);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_degenerate();
        test_back_to_back();
        test_input_change();
        test_reset_mid();
`ifdef EDGE_GEN_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
